// File: rtl/fetch_stage_pkg.sv
// Shared MIPS pipeline definitions used by the IF stage and its consumers.
package mips_pkg;

  // add $0,$0,$0: placed in IF/ID on flush, reset and out-of-range fetches
  localparam logic [31:0] NOP_INSTR = 32'h0000_0020;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] FN_ADD   = 6'b100000;
  localparam logic [5:0] FN_SLT   = 6'b101010;

  // IF/ID pipeline register contents, shared with the decode stage
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        valid;
  } fd_reg_t;

endpackage

// File: rtl/fetch_stage_if.sv
// Control, redirect, program-load and IF/ID output signals of the fetch stage.
interface fetch_stage_if #(
  parameter int unsigned IMEM_DEPTH = 128
);
  localparam int unsigned AW = $clog2(IMEM_DEPTH);

  logic          stall_i;
  logic          flush_i;
  logic          br_taken_i;
  logic [31:0]   br_target_i;
  logic          imem_we_i;
  logic [AW-1:0] imem_waddr_i;
  logic [31:0]   imem_wdata_i;
  logic [31:0]   pc_o;
  logic [31:0]   fd_pc_o;
  logic [31:0]   fd_instr_o;
  logic          fd_valid_o;
  logic          pc_oob_o;

  modport master (
    output stall_i, flush_i, br_taken_i, br_target_i,
           imem_we_i, imem_waddr_i, imem_wdata_i,
    input  pc_o, fd_pc_o, fd_instr_o, fd_valid_o, pc_oob_o
  );

  modport slave (
    input  stall_i, flush_i, br_taken_i, br_target_i,
           imem_we_i, imem_waddr_i, imem_wdata_i,
    output pc_o, fd_pc_o, fd_instr_o, fd_valid_o, pc_oob_o
  );

endinterface

// File: rtl/fetch_stage.sv
// MIPS instruction-fetch stage: PC register, word-addressed instruction
// memory and the IF/ID pipeline register.
module fetch_stage #(
  parameter int unsigned IMEM_DEPTH = 128,
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR  = mips_pkg::NOP_INSTR
) (
  input  logic          clk,
  input  logic          rst,
  fetch_stage_if.slave  bus
);

  localparam int unsigned AW = $clog2(IMEM_DEPTH);

  // `instruction` and `PC` keep their flat names so benches can preload them
  // hierarchically; the array is therefore kept inline rather than in a submodule.
  logic [31:0] instruction [IMEM_DEPTH];
  logic [31:0] PC;

  mips_pkg::fd_reg_t fd_q, fd_d;
  logic [31:0]       pc_d;
  logic              oob_q, oob_d;

  logic              in_range;
  logic [AW-1:0]     rd_idx;
  logic [31:0]       fetch_word;
  logic [31:0]       pc_plus4;

  assign pc_plus4 = PC + 32'd4;
  assign in_range = (PC[31:2] < 30'(IMEM_DEPTH));
  assign rd_idx   = PC[AW+1:2];

  // Asynchronous read; out-of-range fetches return a NOP
  always_comb begin
    fetch_word = NOP_INSTR;
    if (in_range) fetch_word = instruction[rd_idx];
  end

  // Synchronous program-load port; memory is never cleared by reset
  always_ff @(posedge clk) begin
    if (bus.imem_we_i) instruction[bus.imem_waddr_i] <= bus.imem_wdata_i;
  end

  // Next-state selection: branch beats stall, stall beats flush/normal
  always_comb begin
    pc_d  = PC;
    fd_d  = fd_q;
    oob_d = oob_q | ~in_range;
    if (bus.br_taken_i) begin
      pc_d = {bus.br_target_i[31:2], 2'b00};
      fd_d = '{pc: pc_plus4, instr: NOP_INSTR, valid: 1'b0};
    end else if (bus.stall_i) begin
      pc_d = PC;
      fd_d = fd_q;
    end else if (bus.flush_i) begin
      pc_d = pc_plus4;
      fd_d = '{pc: pc_plus4, instr: NOP_INSTR, valid: 1'b0};
    end else begin
      pc_d = pc_plus4;
      fd_d = '{pc: pc_plus4, instr: fetch_word, valid: in_range};
    end
  end

  // PC, IF/ID and sticky out-of-range flag registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      PC    <= RESET_PC;
      fd_q  <= '{pc: '0, instr: NOP_INSTR, valid: 1'b0};
      oob_q <= 1'b0;
    end else begin
      PC    <= pc_d;
      fd_q  <= fd_d;
      oob_q <= oob_d;
    end
  end

  assign bus.pc_o       = PC;
  assign bus.fd_pc_o    = fd_q.pc;
  assign bus.fd_instr_o = fd_q.instr;
  assign bus.fd_valid_o = fd_q.valid;
  assign bus.pc_oob_o   = oob_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Scoreboard bench for fetch_stage: stimulus pushes expected IF state per edge,
// a monitor pops and compares after each rising edge.
module tb_fetch_stage;

  localparam logic [31:0] NOP = 32'h0000_0020;

  typedef struct {
    int          id;
    logic [31:0] pc;
    logic [31:0] fdpc;
    logic [31:0] instr;
    logic        valid;
    logic        oob;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks = 0;
  int   errors = 0;
  int   step_id = 0;
  exp_t exp_q [$];

  logic [31:0] prog [10] = '{32'h8C03_0000, 32'h8C04_0004, 32'h0064_2820,
                             32'h00A6_382A, 32'h0043_1820, 32'hA000_0005,
                             32'hA000_0006, 32'hA000_0007, 32'hA000_0008,
                             32'h1022_0005};

  always #5 clk = ~clk;

  fetch_stage_if #(.IMEM_DEPTH(128)) bus ();

  fetch_stage #(.IMEM_DEPTH(128), .RESET_PC(32'h0), .NOP_INSTR(NOP)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic chk(input string name, input int id, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s step %0d: got %h expected %h", name, id, act, exp);
    end
  endtask

  // Monitor: compares DUT state shortly after each rising edge
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("pc_o",       e.id, bus.pc_o,       e.pc);
        chk("fd_pc_o",    e.id, bus.fd_pc_o,    e.fdpc);
        chk("fd_instr_o", e.id, bus.fd_instr_o, e.instr);
        chk("fd_valid_o", e.id, 32'(bus.fd_valid_o), 32'(e.valid));
        chk("pc_oob_o",   e.id, 32'(bus.pc_oob_o),   32'(e.oob));
      end
    end
  end

  // Called at a falling edge: drive inputs, queue expectation, advance one cycle
  task automatic step(input logic r, input logic st, input logic fl,
                      input logic br, input logic [31:0] tgt,
                      input logic we, input logic [6:0] wa, input logic [31:0] wd,
                      input logic [31:0] epc, input logic [31:0] efd,
                      input logic [31:0] ei, input logic ev, input logic eoob);
    exp_t e;
    rst              = r;
    bus.stall_i      = st;
    bus.flush_i      = fl;
    bus.br_taken_i   = br;
    bus.br_target_i  = tgt;
    bus.imem_we_i    = we;
    bus.imem_waddr_i = wa;
    bus.imem_wdata_i = wd;
    step_id++;
    e = '{id: step_id, pc: epc, fdpc: efd, instr: ei, valid: ev, oob: eoob};
    exp_q.push_back(e);
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic go(input logic st, input logic fl, input logic br,
                    input logic [31:0] tgt, input logic [31:0] epc,
                    input logic [31:0] efd, input logic [31:0] ei,
                    input logic ev, input logic eoob);
    step(1'b1, st, fl, br, tgt, 1'b0, 7'd0, 32'h0, epc, efd, ei, ev, eoob);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int guard;
    bus.stall_i = 0; bus.flush_i = 0; bus.br_taken_i = 0; bus.br_target_i = '0;
    bus.imem_we_i = 0; bus.imem_waddr_i = '0; bus.imem_wdata_i = '0;
    @(negedge clk);
    // Program load while held in reset: IF state must stay at reset values
    for (int i = 0; i < 10; i++)
      step(1'b0, 0, 0, 0, 32'h0, 1'b1, 7'(i), prog[i], 32'h0, 32'h0, NOP, 1'b0, 1'b0);
    step(1'b0, 0, 0, 0, 32'h0, 1'b1, 7'd127, 32'hDEAD_BEEF, 32'h0, 32'h0, NOP, 1'b0, 1'b0);

    // Sequential fetch from reset
    go(0,0,0,0, 32'd4,  32'd4,  32'h8C03_0000, 1, 0);
    go(0,0,0,0, 32'd8,  32'd8,  32'h8C04_0004, 1, 0);
    go(0,0,0,0, 32'd12, 32'd12, 32'h0064_2820, 1, 0);
    go(0,0,0,0, 32'd16, 32'd16, 32'h00A6_382A, 1, 0);
    go(0,0,0,0, 32'd20, 32'd20, 32'h0043_1820, 1, 0);
    go(0,0,0,0, 32'd24, 32'd24, 32'hA000_0005, 1, 0);
    go(0,0,0,0, 32'd28, 32'd28, 32'hA000_0006, 1, 0);
    go(0,0,0,0, 32'd32, 32'd32, 32'hA000_0007, 1, 0);
    go(0,0,0,0, 32'd36, 32'd36, 32'hA000_0008, 1, 0);
    go(0,0,0,0, 32'd40, 32'd40, 32'h1022_0005, 1, 0);
    // Branch at PC=40 to 16, then fetch word 4
    go(0,0,1,32'd16, 32'd16, 32'd44, NOP, 0, 0);
    go(0,0,0,0,      32'd20, 32'd20, 32'h0043_1820, 1, 0);
    // Get to PC=8 with a valid IF/ID, then stall three edges
    go(0,0,1,32'd4,  32'd4,  32'd24, NOP, 0, 0);
    go(0,0,0,0,      32'd8,  32'd8,  32'h8C04_0004, 1, 0);
    go(1,0,0,0,      32'd8,  32'd8,  32'h8C04_0004, 1, 0);
    go(1,0,0,0,      32'd8,  32'd8,  32'h8C04_0004, 1, 0);
    go(1,0,0,0,      32'd8,  32'd8,  32'h8C04_0004, 1, 0);
    // stall+flush: stall wins
    go(1,1,0,0,      32'd8,  32'd8,  32'h8C04_0004, 1, 0);
    // stall+branch: branch wins
    go(1,0,1,32'h24, 32'h24, 32'd12, NOP, 0, 0);
    go(0,0,0,0,      32'h28, 32'h28, 32'h1022_0005, 1, 0);
    // Flush alone at PC=12
    go(0,0,1,32'd8,  32'd8,  32'h2C, NOP, 0, 0);
    go(0,0,0,0,      32'd12, 32'd12, 32'h0064_2820, 1, 0);
    go(0,1,0,0,      32'd16, 32'd16, NOP, 0, 0);
    // Boundary: last word in range, then out of range and sticky flag
    go(0,0,1,32'd508, 32'd508, 32'd20,  NOP, 0, 0);
    go(0,0,0,0,       32'd512, 32'd512, 32'hDEAD_BEEF, 1, 0);
    go(0,0,0,0,       32'd516, 32'd516, NOP, 0, 1);
    go(0,0,0,0,       32'd520, 32'd520, NOP, 0, 1);
    // Misaligned target is word-aligned
    go(0,0,1,32'h13,  32'h10,  32'd524, NOP, 0, 1);
    // Write to the word being fetched: old word captured, new word next time
    step(1'b1, 0,0,0, 32'h0, 1'b1, 7'd4, 32'hCAFE_F00D,
         32'h14, 32'h14, 32'h0043_1820, 1'b1, 1'b1);
    go(0,0,1,32'h10,  32'h10,  32'h18, NOP, 0, 1);
    go(0,0,0,0,       32'h14,  32'h14, 32'hCAFE_F00D, 1, 1);
    // 32-bit PC wrap
    go(0,0,1,32'hFFFF_FFFC, 32'hFFFF_FFFC, 32'h18, NOP, 0, 1);
    go(0,0,0,0,       32'h0,   32'h0,  NOP, 0, 1);
    // Reset mid-run clears the sticky flag; first edge after release fetches RESET_PC
    step(1'b0, 0,0,0, 32'h0, 1'b0, 7'd0, 32'h0, 32'h0, 32'h0, NOP, 1'b0, 1'b0);
    go(0,0,0,0,       32'd4,   32'd4,  32'h8C03_0000, 1, 0);

    guard = 0;
    while (exp_q.size() > 0 && guard < 10) begin
      @(negedge clk);
      guard++;
    end
    if (exp_q.size() > 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction-fetch stage of the 5-stage MIPS pipeline; feeds the ID stage through the IF/ID pipeline register.
- Holds the PC and a word-addressed instruction memory.
- Accepts branch redirects from downstream, stall and flush from the hazard logic, and a write port for program loading.
- The memory array `instruction` and register `PC` are also preloaded hierarchically by benches (cpu.IF.instruction[n], cpu.IF.PC), so those identifiers are part of the interface.

Parameters:
- IMEM_DEPTH, 128, number of 32-bit instruction words.
- RESET_PC, 32'h0000_0000, PC value on reset.
- NOP_INSTR, 32'h0000_0020, instruction injected on flush/reset/out-of-range (add $0,$0,$0).

Ports:
- clk  in  1  pipeline clock, rising-edge active.
- rst  in  1  asynchronous, active-low reset (0 = reset asserted).
- stall_i  in  1  hold PC and IF/ID contents.
- flush_i  in  1  load NOP_INSTR into IF/ID this edge.
- br_taken_i  in  1  redirect request from the branch-resolve stage.
- br_target_i  in  32  byte address of the branch target.
- imem_we_i  in  1  instruction-memory write enable.
- imem_waddr_i  in  $clog2(IMEM_DEPTH)  word address for writes.
- imem_wdata_i  in  32  write data.
- pc_o  out  32  current PC (address being fetched).
- fd_pc_o  out  32  IF/ID PC+4 of the latched instruction (FD_PC).
- fd_instr_o  out  32  IF/ID instruction.
- fd_valid_o  out  1  IF/ID holds a real fetched instruction.
- pc_oob_o  out  1  sticky flag: fetch attempted beyond IMEM_DEPTH.

Behaviour:
- Reset (rst=0, async): PC=RESET_PC, fd_instr_o=NOP_INSTR, fd_pc_o=0, fd_valid_o=0, pc_oob_o=0. Memory contents are not cleared.
- Fetch read is combinational: word = instruction[PC[31:2]]. It is captured into IF/ID at the rising edge, so latency from PC to fd_instr_o is 1 cycle.
- Per-edge priority: br_taken_i > stall_i > normal. flush_i combines as listed below.
- Normal: PC<=PC+4; fd_instr<=word; fd_pc<=PC+4; fd_valid<=1.
- br_taken_i=1:
  - PC<={br_target_i[31:2],2'b00}. Low 2 bits are forced to 0.
  - IF/ID<=NOP_INSTR with fd_valid=0, since the wrong-path fetch is discarded.
  - This takes effect even when stall_i=1.
- stall_i=1, no branch: PC and IF/ID unchanged. flush_i is ignored while stalled.
- flush_i=1, no stall, no branch: PC<=PC+4; IF/ID<=NOP_INSTR, fd_pc<=PC+4, fd_valid<=0.
- Out of range (PC[31:2] >= IMEM_DEPTH):
  - The fetched word is NOP_INSTR and fd_valid<=0.
  - pc_oob_o is set at that edge and stays set until reset.
  - PC keeps incrementing.
- PC arithmetic is 32-bit modulo: 32'hFFFF_FFFC+4 wraps to 0.
- imem write at the rising edge when imem_we_i=1. If the write address equals the fetch address on the same edge, IF/ID captures the old word and the new word is visible from the next read.
- Reset released mid-operation: the first edge after rst rises fetches RESET_PC.

Decomposition:
- Shared package mips_pkg holds:
  - NOP_INSTR.
  - Opcode/funct constants (OP_RTYPE 6'b000000, OP_LW 6'b100011, OP_SW 6'b101011, OP_BEQ 6'b000100, FN_ADD 6'b100000, FN_SLT 6'b101010).
  - Typedef fd_reg_t {pc, instr, valid}, shared with ID.
- One natural sub-module: imem_array. It holds the `instruction` storage, one async read port and one sync write port. It is instantiated with instance name keeping hierarchical path IF.instruction reachable (or the array is kept inline if the tool flow needs the flat path).

Test Plan:
- Reset: instruction[0]=32'h8C03_0000 (lw $3,0($0)). Hold rst=0 for 12 ns, then release. Required: fd_valid=0 during reset. After the first edge, pc_o=4, fd_instr=32'h8C03_0000, fd_pc=4, fd_valid=1.
- Sequential fetch: load words 0..4. Required: after 5 edges pc_o=20 and fd_pc sequence 4,8,12,16,20 with matching words.
- Branch: at PC=40 (beq at word 9), assert br_taken with br_target=16 for one edge. Required: pc_o=16, fd_instr=32'h20, fd_valid=0. The next edge gives fd_instr=instruction[4]=32'h0043_1820.
- Stall and priority:
  - stall_i=1 for 3 edges at PC=8: pc_o and IF/ID are frozen.
  - stall+flush: stall wins, no change.
  - stall+br_taken (target 0x24): pc_o=0x24 and IF/ID=NOP.
- Flush only at PC=12: fd_instr=32'h20, fd_valid=0, and pc_o=16.
- Boundary:
  - Force PC=508: the fetch is in range.
  - Next edge PC=512: fd_instr=NOP, fd_valid=0, pc_oob_o=1, and it stays 1 until rst=0.
  - br_target=0x13 gives pc_o=0x10.
  - imem write to the current fetch address returns the old word that cycle.
